// File: rtl/param_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : param_alu_pkg
// Description : Shared definitions for the sequential parametrised ALU:
//               the 16-entry opcode map and the controller state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package param_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_NOT  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_NAND = 4'b0100,
        OP_NOR  = 4'b0101,
        OP_XNOR = 4'b0110,
        OP_ADD  = 4'b0111,
        OP_SUB  = 4'b1000,
        OP_MUL  = 4'b1001,
        OP_CMP  = 4'b1010,
        OP_SLL  = 4'b1011,
        OP_SRL  = 4'b1100,
        OP_SLA  = 4'b1101,
        OP_SRA  = 4'b1110,
        OP_ACC  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : param_alu_pkg
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative unsigned shift-add multiplier. A start pulse loads
//               the operands; one partial product is added per cycle for
//               WIDTH cycles. done is high during the cycle whose edge
//               performs the final iteration, and product then shows the
//               value that iteration produces.
// Ports       : clock, reset (sync, active-high), start, a, b -> done, product
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 4,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [RES_W-1:0] product
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [RES_W-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [RES_W-1:0] r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    // Next partial product is exposed directly so the caller can capture the
    // final value on the same edge as the last iteration.
    assign product = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign done    = r_busy && (r_cnt == C_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_prod   <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (done) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

endmodule : alu_mul_seq
`default_nettype wire

// File: rtl/param_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : param_alu_seq
// Description : Registered WIDTH-bit ALU with valid/ready command and result
//               handshakes, iterative multiplier and command-driven
//               accumulator.
// Ports       : clock, reset (sync, active-high)
//               in_valid/in_ready, a, b, opcode, acc_clr  (command side)
//               out_valid/out_ready, result, flag_zero, flag_carry (result)
// Options     : PARAM_ALU_SAT_EN - saturating ADD/SUB/ACC instead of wrap
// Revision    : 1.0 - initial release
// ============================================================================
module param_alu_seq
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry
);

    state_e           r_state;
    state_e           w_state_next;
    logic [RES_W-1:0] r_result;
    logic [RES_W-1:0] r_acc;
    logic             r_zero;
    logic             r_carry;

    op_e              w_op;
    logic             w_accept;
    logic             w_mul_done;
    logic [RES_W-1:0] w_mul_prod;

    logic [RES_W-1:0] w_a_ext;
    logic [RES_W-1:0] w_b_ext;
    logic [WIDTH:0]   w_sum;
    logic [RES_W-1:0] w_diff;
    logic [RES_W-1:0] w_cat;
    logic [RES_W:0]   w_acc_sum;
    logic [RES_W-1:0] w_res;
    logic             w_carry;

    assign w_op      = op_e'(opcode);
    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_a_ext   = {{WIDTH{1'b0}}, a};
    assign w_b_ext   = {{WIDTH{1'b0}}, b};
    assign w_sum     = {1'b0, a} + {1'b0, b};
    // RES_W exceeds WIDTH+1, so the RES_W-bit difference is already the
    // sign-extended two's complement value.
    assign w_diff    = w_a_ext - w_b_ext;
    assign w_cat     = {a, b};
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_a_ext};

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (w_accept && (w_op == OP_MUL)),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    // Single-cycle datapath; for ACC w_res is also the new accumulator value.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (w_op)
            OP_AND:  w_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:   w_res = {{WIDTH{1'b0}}, a | b};
            OP_NOT:  w_res = {~a, ~b};
            OP_XOR:  w_res = {{WIDTH{1'b0}}, a ^ b};
            OP_NAND: w_res = {{WIDTH{1'b0}}, ~(a & b)};
            OP_NOR:  w_res = {{WIDTH{1'b0}}, ~(a | b)};
            OP_XNOR: w_res = {{WIDTH{1'b0}}, ~(a ^ b)};
            OP_ADD: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_sum};
                w_carry = w_sum[WIDTH];
`ifdef PARAM_ALU_SAT_EN
                if (w_sum[WIDTH]) begin
                    w_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                end
`endif
            end
            OP_SUB: begin
                w_res   = w_diff;
                w_carry = (a < b);
`ifdef PARAM_ALU_SAT_EN
                if (a < b) begin
                    w_res = '0;
                end
`endif
            end
            OP_MUL:  w_res = '0;
            OP_CMP: begin
                if (a > b)      w_res = {{(RES_W-2){1'b0}}, 2'b10};
                else if (a < b) w_res = {{(RES_W-2){1'b0}}, 2'b01};
                else            w_res = {{(RES_W-2){1'b0}}, 2'b11};
            end
            OP_SLL, OP_SLA: w_res = w_cat << 1;
            OP_SRL:  w_res = w_cat >> 1;
            OP_SRA:  w_res = {w_cat[RES_W-1], w_cat[RES_W-1:1]};
            OP_ACC: begin
                w_res   = w_acc_sum[RES_W-1:0];
                w_carry = w_acc_sum[RES_W];
`ifdef PARAM_ALU_SAT_EN
                if (w_acc_sum[RES_W]) begin
                    w_res = '1;
                end
`endif
                // A coincident clear takes priority over the accumulate.
                if (acc_clr) begin
                    w_res   = '0;
                    w_carry = 1'b0;
                end
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = (w_op == OP_MUL) ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: begin
                if (w_mul_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
        end else begin
            if (acc_clr) begin
                r_acc <= '0;
            end else if (w_accept && (w_op == OP_ACC)) begin
                r_acc <= w_res;
            end

            if (w_accept && (w_op != OP_MUL)) begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_carry  <= w_carry;
            end else if ((r_state == ST_EXEC) && w_mul_done) begin
                r_result <= w_mul_prod;
                r_zero   <= (w_mul_prod == '0);
                r_carry  <= 1'b0;
            end
        end
    end

    assign result     = r_result;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;

endmodule : param_alu_seq
`default_nettype wire

// File: tb/tb_param_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_alu_seq
// Description : Scoreboard bench for param_alu_seq (WIDTH=4). Expected
//               results come from an arithmetic reference model; a monitor
//               pops and compares on every result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_alu_seq;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    opcode;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          flag_zero;
    logic          flag_carry;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          z;
        logic          c;
    } exp_t;

    exp_t    sb_q[$];
    int      checks     = 0;
    int      failures   = 0;
    longint  model_acc  = 0;
    bit      rand_ready = 1'b0;

    param_alu_seq #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    always #5 clock = ~clock;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic straight from the opcode map.
    function automatic exp_t model(longint av, longint bv, int op, bit clr);
        longint mw  = (longint'(1) << W) - 1;
        longint mr  = (longint'(1) << RW) - 1;
        longint top = longint'(1) << (RW - 1);
        longint cat = av * (longint'(1) << W) + bv;
        longint r   = 0;
        bit     c   = 1'b0;
        exp_t   e;
        case (op)
            0:  r = av & bv;
            1:  r = av | bv;
            2:  r = ((~av & mw) << W) | (~bv & mw);
            3:  r = av ^ bv;
            4:  r = ~(av & bv) & mw;
            5:  r = ~(av | bv) & mw;
            6:  r = ~(av ^ bv) & mw;
            7: begin
                r = av + bv;
                c = (r > mw);
`ifdef PARAM_ALU_SAT_EN
                if (c) r = mw;
`endif
            end
            8: begin
                c = (av < bv);
                r = (av - bv) & mr;
`ifdef PARAM_ALU_SAT_EN
                if (c) r = 0;
`endif
            end
            9:  r = av * bv;
            10: r = (av > bv) ? 2 : ((av < bv) ? 1 : 3);
            11, 13: r = (cat * 2) & mr;
            12: r = cat / 2;
            14: r = cat / 2 + ((cat >= top) ? top : 0);
            default: begin
                if (clr) begin
                    r = 0;
                end else begin
                    r = model_acc + av;
                    c = (r > mr);
`ifdef PARAM_ALU_SAT_EN
                    if (c) r = mr;
`else
                    r = r & mr;
`endif
                end
                model_acc = r;
            end
        endcase
        if (clr) model_acc = 0;
        e.res = RW'(r);
        e.z   = (r == 0);
        e.c   = c;
        return e;
    endfunction

    // Issue one command, then measure accept-to-out_valid latency.
    task automatic issue(int av, int bv, int op, bit clr);
        int waitc = 0;
        int lat   = 0;
        @(negedge clock);
        while (!in_ready && waitc < 200) begin
            @(negedge clock);
            waitc++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        a        = W'(av);
        b        = W'(bv);
        opcode   = 4'(op);
        acc_clr  = clr;
        in_valid = 1'b1;
        sb_q.push_back(model(av, bv, op, clr));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < 50);
        chk("latency", lat, (op == 9) ? W + 1 : 1);
    endtask

    // Monitor: compare on every completed result handshake.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("flag_zero", flag_zero, e.z);
                chk("flag_carry", flag_carry, e.c);
            end
        end
    end

    always @(posedge clock) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : stim
        int stray;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_zero, flag_carry}, 0);

        // Accumulator: first result also proves acc starts at zero.
        repeat (17) issue(15, 0, 15, 1'b0);
        issue(15, 0, 15, 1'b0);
        issue(2, 0, 15, 1'b1);

        // Directed corner cases.
        issue(13, 11, 9, 1'b0);
        issue(3, 5, 8, 1'b0);
        issue(9, 12, 14, 1'b0);
        issue(15, 15, 7, 1'b0);
        issue(0, 0, 9, 1'b0);
        issue(7, 7, 10, 1'b0);

        // Backpressure: result held while a new command is offered.
        @(posedge clock);
        #1 out_ready = 1'b0;
        issue(7, 6, 7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a        = 4'd1;
            b        = 4'd1;
            opcode   = 4'd0;
            in_valid = 1'b1;
            @(negedge clock);
            chk("hold_result", result, 8'h0D);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        stray = 0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid) stray++;
        end
        chk("ignored_cmd_no_output", stray, 0);

        // Abort a multiply with reset in EXEC.
        @(negedge clock);
        a        = 4'd15;
        b        = 4'd15;
        opcode   = 4'd9;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        model_acc = 0;
        @(negedge clock);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        stray = 0;
        repeat (10) begin
            @(negedge clock);
            if (out_valid) stray++;
        end
        chk("abort_no_output", stray, 0);
        issue(5, 0, 15, 1'b0);

        // Randomised traffic with random consumer backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), ($urandom_range(0, 7) == 0));
        end
        rand_ready = 1'b0;
        @(posedge clock);
        #1 out_ready = 1'b1;
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clock);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_param_alu_seq
`default_nettype wire
